hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
Parametrised successor to the current hazard block for the 5-stage RV32 pipeline. It keeps combinational forwarding, load-use stall and branch-flush generation, and adds three things:
- a register scoreboard plus countdown tracker for one variable-latency execute unit (MUL/DIV), with interlocks for RAW, WAW and structural hazards;
- a third forwarding source, the long-unit completion bypass;
- saturating stall and flush performance counters.
It sits beside the control and data pipelines in the core top level.

Parameters:
NUM_REGS, 32, architectural register count (x0 hard-wired zero)
REG_AW, 5, register index width, equal to clog2(NUM_REGS)
MAX_LAT, 34, maximum long-op latency in cycles
LAT_W, 6, counter width, equal to clog2(MAX_LAT+1)
CNT_W, 32, performance counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_d_rs1 / i_d_rs2  in  REG_AW  decode-stage source registers
i_d_uses_rs1 / i_d_uses_rs2  in  1  decode instruction actually reads rs1 / rs2
i_d_rd  in  REG_AW  decode destination register
i_d_we  in  1  decode instruction writes the regfile
i_d_long  in  1  decode instruction is a long op
i_e_rs1 / i_e_rs2 / i_e_rd  in  REG_AW  execute-stage registers
i_e_result_src  in  2  execute final-result select (RES_MEM marks a load)
i_e_pc_src  in  1  branch or jump taken in execute
i_e_long_issue  in  1  long op entering the unit this cycle
i_e_long_lat  in  LAT_W  latency of the issuing op
i_m_rd / i_w_rd  in  REG_AW  memory / writeback destination registers
i_m_we / i_w_we  in  1  memory / writeback regfile write enables
o_fwd_a / o_fwd_b  out  2  ALU operand forward selects
o_f_stall  out  1  hold PC
o_fd_stall  out  1  hold F/D register
o_fd_flush  out  1  clear F/D register
o_de_flush  out  1  clear D/E register
o_long_done  out  1  long result valid; writes via dedicated regfile port
o_long_rd  out  REG_AW  destination register of the completing long op
o_long_busy  out  1  long-unit counter nonzero
o_stall_cycles  out  CNT_W  saturating count of cycles with o_f_stall=1
o_flush_events  out  CNT_W  saturating count of cycles with i_e_pc_src=1

Behaviour:
- Forwarding, per operand s in {e_rs1, e_rs2}, all combinational. Forwarding only applies when s is nonzero.
  - Priority 1: FWD_M (10) if i_m_we and i_m_rd==s.
  - Priority 2: FWD_W (01) if i_w_we and i_w_rd==s.
  - Priority 3: FWD_L (11) if o_long_done and o_long_rd==s.
  - Otherwise FWD_NONE (00).
- Load-use: i_e_result_src==RES_MEM, i_e_rd!=0, and i_e_rd matches a used decode source.
- Scoreboard RAW: sb[rs] set for a used decode source, and that rs is not completing this cycle (o_long_done with o_long_rd==rs clears the hazard).
- WAW: i_d_we and sb[i_d_rd], with i_d_rd!=0.
- Structural: i_d_long and o_long_busy and not o_long_done.
- Stall = load-use OR RAW OR WAW OR structural. When stall=1: o_f_stall=o_fd_stall=1 and o_de_flush=1.
- Branch (i_e_pc_src=1): o_fd_flush=1, o_de_flush=1, and o_f_stall and o_fd_stall are forced 0. Branch overrides stall, because the stalled decode instruction is on the wrong path.
- Long tracker (sequential):
  - On i_e_long_issue, load count with max(i_e_long_lat,1), capture rd, and set sb[rd] if rd!=0.
  - Otherwise, while count!=0, decrement.
  - o_long_done = (count==1), combinational. On that edge sb[o_long_rd] clears.
  - Issue while count>1 is a protocol violation; the structural interlock prevents it. The bench asserts it never occurs.
  - Issue in the same cycle as done is legal: the new op reloads the counter and the old bit clears. If both name the same rd, set wins.
  - Latency above MAX_LAT saturates to MAX_LAT.
- Counters increment by 1 per qualifying cycle and hold at all-ones.
- Reset (async): sb=0, count=0, o_long_rd=0, both counters 0. Outputs then evaluate to: fwd 00, no stall, no flush, o_long_done=0, o_long_busy=0. Reset mid long op abandons it; no done pulse is produced.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10, FWD_L=2'b11.
  - Result-source constants: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10.
- Sub-module long_op_tracker: counter, captured rd, and NUM_REGS-bit scoreboard vector, with issue/done ports. The top-level module holds the combinational hazard logic and the perf counters.

Test Plan:
- Forwarding priority: m_rd=w_rd=5, both writes enabled, e_rs1=5 -> o_fwd_a=10. With e_rs2=0 and w_rd=0, w_we=1 -> o_fwd_b=00.
- Load-use: e_result_src=01, e_rd=7, d_rs2=7, d_uses_rs2=1 -> o_f_stall=o_fd_stall=o_de_flush=1 for exactly 1 cycle. Same stimulus with d_uses_rs2=0 -> no stall.
- Long op: issue lat=4, rd=9, then d_rs1=9 used -> stall for 3 cycles. o_long_done with o_long_rd=9 is asserted on the 4th cycle, stall drops that cycle, and o_fwd_a=11 once the op reaches execute with e_rs1=9.
- Structural and WAW: busy lat=6; decode long op -> stalled until done. Decode write to the busy rd -> stalled. lat=0 issue -> done after 1 cycle.
- Branch vs stall: load-use hazard and i_e_pc_src=1 in the same cycle -> o_fd_flush=o_de_flush=1 and o_f_stall=0. o_flush_events increments by 1.
- Reset: assert i_rst asynchronously mid long op (count=3) -> busy/done/sb clear immediately with no done pulse; counters read 0. With CNT_W=4, 20 stall cycles -> o_stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32 hazard / scoreboard unit.
// Forward-select encoding and final-result-source constants.
// No timing of its own; consumed combinationally.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10,
    FWD_L    = 2'b11
  } fwd_sel_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/hazard_scoreboard_long_op_tracker.sv
// Purpose: countdown tracker and pending-write scoreboard for the single MUL/DIV unit.
// Latency: done asserts exactly max(lat,1) cycles after the issue edge (lat clamped to MAX_LAT).
// Backpressure: none; the caller must hold issue off while busy and not done.
module long_op_tracker
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 34,
  parameter int LAT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic                done,
  output logic [REG_AW-1:0]   done_rd,
  output logic                busy,
  output logic [NUM_REGS-1:0] sb
);

  logic [LAT_W-1:0]    count;
  logic [LAT_W-1:0]    eff_lat;
  logic [NUM_REGS-1:0] sb_nxt;

  assign done = (count == LAT_W'(1));
  assign busy = (count != '0);

  // Zero latency still needs one cycle to complete; oversized latencies clamp.
  always_comb begin
    eff_lat = issue_lat;
    if (issue_lat == '0) begin
      eff_lat = LAT_W'(1);
    end else if (issue_lat > LAT_W'(MAX_LAT)) begin
      eff_lat = LAT_W'(MAX_LAT);
    end
  end

  // Completing op clears its bit first so a same-rd reissue leaves it set.
  always_comb begin
    sb_nxt = sb;
    if (done) begin
      sb_nxt[done_rd] = 1'b0;
    end
    if (issue && (issue_rd != '0)) begin
      sb_nxt[issue_rd] = 1'b1;
    end
  end

  // Countdown, captured destination and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      done_rd <= '0;
      sb      <= '0;
    end else begin
      sb <= sb_nxt;
      if (issue) begin
        count   <= eff_lat;
        done_rd <= issue_rd;
      end else if (count != '0) begin
        count <= count - LAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose: forwarding, load-use/scoreboard/structural interlocks, branch flush and perf counters.
// Latency: all hazard outputs combinational; counters update on the next clock edge.
// Backpressure: stalls F and F/D while bubbling D/E; a taken branch overrides any stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 34,
  parameter int LAT_W    = 6,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_d_rs1,
  input  logic [REG_AW-1:0] i_d_rs2,
  input  logic              i_d_uses_rs1,
  input  logic              i_d_uses_rs2,
  input  logic [REG_AW-1:0] i_d_rd,
  input  logic              i_d_we,
  input  logic              i_d_long,
  input  logic [REG_AW-1:0] i_e_rs1,
  input  logic [REG_AW-1:0] i_e_rs2,
  input  logic [REG_AW-1:0] i_e_rd,
  input  logic [1:0]        i_e_result_src,
  input  logic              i_e_pc_src,
  input  logic              i_e_long_issue,
  input  logic [LAT_W-1:0]  i_e_long_lat,
  input  logic [REG_AW-1:0] i_m_rd,
  input  logic [REG_AW-1:0] i_w_rd,
  input  logic              i_m_we,
  input  logic              i_w_we,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_f_stall,
  output logic              o_fd_stall,
  output logic              o_fd_flush,
  output logic              o_de_flush,
  output logic              o_long_done,
  output logic [REG_AW-1:0] o_long_rd,
  output logic              o_long_busy,
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic [CNT_W-1:0]  o_flush_events
);

  logic [NUM_REGS-1:0] sb;
  logic load_use, raw, waw, structural, stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  long_op_tracker #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .MAX_LAT  (MAX_LAT),
    .LAT_W    (LAT_W)
  ) u_tracker (
    .clk       (i_clk),
    .rst       (i_rst),
    .issue     (i_e_long_issue),
    .issue_lat (i_e_long_lat),
    .issue_rd  (i_e_rd),
    .done      (o_long_done),
    .done_rd   (o_long_rd),
    .busy      (o_long_busy),
    .sb        (sb)
  );

  function automatic fwd_sel_t pick_fwd(
    input logic [REG_AW-1:0] s,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              l_done,
    input logic [REG_AW-1:0] l_rd
  );
    if (s == '0)                return FWD_NONE;
    else if (m_we && m_rd == s) return FWD_M;
    else if (w_we && w_rd == s) return FWD_W;
    else if (l_done && l_rd == s) return FWD_L;
    else                        return FWD_NONE;
  endfunction

  // Operand bypass: memory beats writeback beats long-unit completion.
  always_comb begin
    o_fwd_a = pick_fwd(i_e_rs1, i_m_we, i_m_rd, i_w_we, i_w_rd, o_long_done, o_long_rd);
    o_fwd_b = pick_fwd(i_e_rs2, i_m_we, i_m_rd, i_w_we, i_w_rd, o_long_done, o_long_rd);
  end

  // Interlock sources; a register completing this cycle is already bypassable.
  always_comb begin
    load_use = (i_e_result_src == RES_MEM) && (i_e_rd != '0) &&
               ((i_d_uses_rs1 && i_d_rs1 == i_e_rd) ||
                (i_d_uses_rs2 && i_d_rs2 == i_e_rd));
    raw = (i_d_uses_rs1 && sb[i_d_rs1] && !(o_long_done && o_long_rd == i_d_rs1)) ||
          (i_d_uses_rs2 && sb[i_d_rs2] && !(o_long_done && o_long_rd == i_d_rs2));
    waw        = i_d_we && (i_d_rd != '0) && sb[i_d_rd];
    structural = i_d_long && o_long_busy && !o_long_done;
    stall      = load_use || raw || waw || structural;
  end

  // The stalled decode instruction is on the wrong path when a branch resolves.
  always_comb begin
    o_f_stall  = stall && !i_e_pc_src;
    o_fd_stall = stall && !i_e_pc_src;
    o_fd_flush = i_e_pc_src;
    o_de_flush = stall || i_e_pc_src;
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (o_f_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (i_e_pc_src && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cycles = stall_cnt;
  assign o_flush_events = flush_cnt;

endmodule
